// File: rtl/cpu_sram_responder_if.sv
// SRAM-like instruction and data port bundle between the single-cycle CPU (master)
// and the unified memory responder (slave).
interface cpu_sram_responder_if;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata,
        output data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata,
        input  data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/cpu_sram_responder.sv
// Unified word array behind the CPU's instruction (read-only) and data ports, with
// combinational reads, store/fetch counters and an optional out-of-bound store trap
// (built when SRAM_OOB_TRAP_EN is defined).
module cpu_sram_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1c00_0000,
    parameter int          ADDR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_sram_responder_if.slave  bus,
    output logic [31:0]          wr_cnt,
    output logic [31:0]          fetch_cnt,
    output logic                 oob_err,
    output logic [31:0]          oob_addr
);
    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           inst_off;
    logic [31:0]           data_off;
    logic [ADDR_WIDTH-1:0] inst_idx;
    logic [ADDR_WIDTH-1:0] data_idx;
    logic                  inst_hit;
    logic                  data_hit;
    logic                  store_ok;

    // The instruction port is read-only; its write strobe and data are deliberately dropped.
    logic unused_inst_write;
    assign unused_inst_write = ^{bus.inst_sram_we, bus.inst_sram_wdata};

    // Addresses below the base wrap to a huge offset and so fall out of range.
    assign inst_off = bus.inst_sram_addr - BASE_ADDR;
    assign data_off = bus.data_sram_addr - BASE_ADDR;
    assign inst_idx = inst_off[ADDR_WIDTH+1:2];
    assign data_idx = data_off[ADDR_WIDTH+1:2];
    assign inst_hit = {1'b0, inst_off} < SPAN;
    assign data_hit = {1'b0, data_off} < SPAN;

    assign bus.inst_sram_rdata = inst_hit ? mem[inst_idx] : 32'h0;
    assign bus.data_sram_rdata = data_hit ? mem[data_idx] : 32'h0;

    assign store_ok = !reset && bus.data_sram_we && data_hit;

    // NOTE: the array has no reset branch on purpose; contents survive reset and a
    // reset term here would also stop the array mapping onto RAM macros.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            mem[data_idx] <= bus.data_sram_wdata;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt    <= 32'h0;
            fetch_cnt <= 32'h0;
        end else begin
            if (store_ok) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (inst_hit) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

`ifdef SRAM_OOB_TRAP_EN
    logic store_oob;
    assign store_oob = !reset && bus.data_sram_we && !data_hit;

    // Only the first violation is recorded; the flag stays sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            oob_err  <= 1'b0;
            oob_addr <= 32'h0;
        end else if (store_oob && !oob_err) begin
            oob_err  <= 1'b1;
            oob_addr <= bus.data_sram_addr;
        end
    end
`else
    assign oob_err  = 1'b0;
    assign oob_addr = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_sram_responder.sv
// Directed bench for cpu_sram_responder: read/write timing, hazards, out-of-bound
// stores, misaligned loads, counters across reset and counter wrap.
module tb_cpu_sram_responder;
`ifdef SRAM_OOB_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] wr_cnt;
    logic [31:0] fetch_cnt;
    logic        oob_err;
    logic [31:0] oob_addr;
    int          n_checks = 0;
    int          n_errors = 0;

    cpu_sram_responder_if bus ();

    cpu_sram_responder dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .wr_cnt    (wr_cnt),
        .fetch_cnt (fetch_cnt),
        .oob_err   (oob_err),
        .oob_addr  (oob_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed=no-finish required=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.data_sram_we    = 1'b1;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
    endtask

    initial begin
        reset               = 1'b1;
        bus.inst_sram_we    = 1'b0;
        bus.inst_sram_addr  = 32'h1bff_fffc;
        bus.inst_sram_wdata = 32'h0;
        bus.data_sram_we    = 1'b0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;

        // Preload known words, then reset again: array must survive, counters must clear.
        store(32'h1c00_0000, 32'h0a0a_0a0a);
        store(32'h1c00_0010, 32'h1111_1111);
        store(32'h1c00_0020, 32'h2222_2222);
        @(negedge clk);
        bus.data_sram_we = 1'b0;
        reset            = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_wr_cnt", wr_cnt, 32'h0);
        check("rst_fetch_cnt", fetch_cnt, 32'h0);
        check("rst_oob_err", {31'h0, oob_err}, 32'h0);
        check("rst_oob_addr", oob_addr, 32'h0);

        // Store, same-cycle load sees old word, next cycle sees new.
        store(32'h1c00_0010, 32'hdead_beef);
        #1;
        check("store_cycle_old", bus.data_sram_rdata, 32'h1111_1111);
        @(negedge clk);
        bus.data_sram_we = 1'b0;
        #1;
        check("store_next_new", bus.data_sram_rdata, 32'hdead_beef);
        check("store_wr_cnt", wr_cnt, 32'd1);
        check("store_fetch_cnt", fetch_cnt, 32'd0);

        // Writes on the instruction port are ignored.
        @(negedge clk);
        bus.inst_sram_we    = 1'b1;
        bus.inst_sram_addr  = 32'h1bff_fffc;
        bus.inst_sram_wdata = 32'h5a5a_5a5a;
        bus.data_sram_addr  = 32'h1c00_0010;
        @(negedge clk);
        bus.inst_sram_we = 1'b0;
        #1;
        check("inst_we_ignored", bus.data_sram_rdata, 32'hdead_beef);
        check("inst_we_wr_cnt", wr_cnt, 32'd1);

        // Store and fetch of the same word in one cycle.
        store(32'h1c00_0020, 32'h1234_5678);
        bus.inst_sram_addr = 32'h1c00_0020;
        #1;
        check("hazard_fetch_old", bus.inst_sram_rdata, 32'h2222_2222);
        @(negedge clk);
        bus.data_sram_we = 1'b0;
        #1;
        check("hazard_fetch_new", bus.inst_sram_rdata, 32'h1234_5678);
        check("hazard_wr_cnt", wr_cnt, 32'd2);
        check("hazard_fetch_cnt", fetch_cnt, 32'd1);
        bus.inst_sram_addr = 32'h1bff_fffc;

        // Out-of-bound stores below the base and one word past the top.
        store(32'h1bff_fffc, 32'haaaa_aaaa);
        store(32'h1c04_0000, 32'hbbbb_bbbb);
        #1;
        check("oob_err_first", {31'h0, oob_err}, {31'h0, TRAP});
        check("oob_addr_first", oob_addr, TRAP ? 32'h1bff_fffc : 32'h0);
        @(negedge clk);
        bus.data_sram_we   = 1'b0;
        bus.data_sram_addr = 32'h1c00_0000;
        #1;
        check("oob_err_sticky", {31'h0, oob_err}, {31'h0, TRAP});
        check("oob_addr_kept", oob_addr, TRAP ? 32'h1bff_fffc : 32'h0);
        check("oob_wr_cnt", wr_cnt, 32'd2);
        check("oob_word0_kept", bus.data_sram_rdata, 32'h0a0a_0a0a);

        // Misaligned load and out-of-range load.
        bus.data_sram_addr = 32'h1c00_0013;
        #1;
        check("misaligned_load", bus.data_sram_rdata, 32'hdead_beef);
        bus.data_sram_addr = 32'h0000_0000;
        #1;
        check("oor_load_zero", bus.data_sram_rdata, 32'h0);
        @(negedge clk);
        #1;
        check("oor_load_no_flag", {31'h0, oob_err}, {31'h0, TRAP});

        // Fetch counting, then reset with a store pending.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset              = 1'b0;
        bus.inst_sram_addr = 32'h1c00_0000;
        repeat (5) @(negedge clk);
        #1;
        check("fetch_cnt_5", fetch_cnt, 32'd5);
        check("fetch_word0", bus.inst_sram_rdata, 32'h0a0a_0a0a);
        reset               = 1'b1;
        bus.data_sram_we    = 1'b1;
        bus.data_sram_addr  = 32'h1c00_0010;
        bus.data_sram_wdata = 32'h5555_5555;
        @(negedge clk);
        reset            = 1'b0;
        bus.data_sram_we = 1'b0;
        #1;
        check("rst2_wr_cnt", wr_cnt, 32'h0);
        check("rst2_fetch_cnt", fetch_cnt, 32'h0);
        check("rst2_oob_err", {31'h0, oob_err}, 32'h0);
        check("rst2_oob_addr", oob_addr, 32'h0);
        check("rst2_store_dropped", bus.data_sram_rdata, 32'hdead_beef);
        bus.inst_sram_addr = 32'h1bff_fffc;

        // Counter wrap: preload wr_cnt to all ones, then one more store.
        @(negedge clk);
        force dut.wr_cnt = 32'hffff_ffff;
        #1;
        release dut.wr_cnt;
        bus.data_sram_we    = 1'b1;
        bus.data_sram_addr  = 32'h1c00_0030;
        bus.data_sram_wdata = 32'hcafe_f00d;
        @(negedge clk);
        bus.data_sram_we = 1'b0;
        #1;
        check("wr_cnt_wrap", wr_cnt, 32'h0);
        check("wrap_store_data", bus.data_sram_rdata, 32'hcafe_f00d);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_sram_responder.md
# cpu_sram_responder

Memory-side responder for the single-cycle CPU's two SRAM-like ports. It holds one unified word array serving the instruction port (read-only) and the data port (read/write). It sits between `mycpu_top` and the testbench/SoC in place of separate inst/data RAM models. Reads are combinational to match the CPU's same-cycle consumption of `*_rdata`. Writes, statistics counters and out-of-bound trapping are sequential.

## Interface
Parameters:
- BASE_ADDR, 32'h1c00_0000, byte address of word 0
- ADDR_WIDTH, 16, word-index width; array depth = 2^ADDR_WIDTH words

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- inst_sram_we  in  1  must be 0; a write on this port is ignored
- inst_sram_addr  in  32  fetch byte address
- inst_sram_wdata  in  32  ignored
- inst_sram_rdata  out  32  fetched word, combinational
- data_sram_we  in  1  store strobe; full 32-bit word write
- data_sram_addr  in  32  load/store byte address
- data_sram_wdata  in  32  store data
- data_sram_rdata  out  32  load word, combinational
- wr_cnt  out  32  committed in-range stores
- fetch_cnt  out  32  in-range fetch cycles
- oob_err  out  1  sticky out-of-bound store flag
- oob_addr  out  32  address of the first out-of-bound store

## Operation
- Index mapping: `off = addr - BASE_ADDR` (32-bit, modulo 2^32). Word index is `off[ADDR_WIDTH+1:2]`. `addr[1:0]` is ignored, so misaligned accesses hit the containing word.
- In-range test: `off < 4*2^ADDR_WIDTH`, evaluated on the 32-bit unsigned `off`. Addresses below the base wrap to large `off` and are out of range.
- Reads: `*_rdata` = `array[index]` if in range, else 32'h0.
  - Reads carry no valid qualifier, so an out-of-range read never flags an error. The CPU drives data address 0 on non-memory cycles, and fetch address 0x1bfffffc around reset.
- Store (`data_sram_we=1`, `reset=0`):
  - In range: commits `data_sram_wdata` at the next edge and increments `wr_cnt`.
  - Out of range: the write is dropped and handled by the trap logic.
- `fetch_cnt` increments on each edge where `reset=0` and the inst address is in range.
- Both counters wrap from 32'hffff_ffff to 0.
- Out-of-bound trap:
  - The first out-of-range store with `oob_err=0` sets `oob_err` and captures `oob_addr`.
  - Later violations change neither output until reset.
- `inst_sram_we=1` has no effect on the array, counters or flags.

## Timing
- Read latency 0: `rdata` follows the address and array combinationally in the same cycle.
- Write latency 1: the array updates at the edge ending the store cycle.
  - Same-cycle read of the written word (either port) returns the OLD value.
  - The next cycle returns the new value.
- Reset values: `wr_cnt`=0, `fetch_cnt`=0, `oob_err`=0, `oob_addr`=0.
- The array is NOT cleared by reset; its contents are preserved across reset.
- Stores with `reset=1` are dropped and neither count nor trap.
- Reset asserted mid-operation:
  - Counters and flags clear at that edge.
  - A store presented in the same cycle is discarded.
- Simultaneous store and fetch of the same word: the fetch gets the old data, and `wr_cnt` and `fetch_cnt` both increment.

## Configuration
- `SRAM_OOB_TRAP_EN` defined: trap logic is built as described in Operation.
- `SRAM_OOB_TRAP_EN` undefined:
  - `oob_err` is tied to 0 and `oob_addr` to 32'h0.
  - Out-of-range stores are still dropped silently.
  - Ports remain present.

## Test plan
- Reset, then store 32'hdeadbeef to 0x1c000010, then load 0x1c000010.
  - In the store cycle, `data_sram_rdata` shows the old value.
  - Next cycle: 32'hdeadbeef, `wr_cnt`=1.
- Same-cycle hazard: store 32'h1234_5678 to 0x1c000020 while fetching 0x1c000020.
  - `inst_sram_rdata` shows the old word.
  - Next cycle it shows 32'h1234_5678.
- Out-of-bound stores: store to 0x1bfffffc, then to 0x1c000000 + 4·2^ADDR_WIDTH.
  - `oob_err`=1 with `oob_addr`=0x1bfffffc, unchanged by the second store.
  - `wr_cnt` unchanged; the word at 0x1c000000 is unchanged.
  - With the macro undefined, `oob_err` stays 0.
- Misaligned load from 0x1c000013 returns the word at 0x1c000010.
  - A load from 0x00000000 returns 0 and leaves `oob_err`=0.
- Hold fetch address 0x1c000000 for 5 cycles after reset, then assert reset with a store pending.
  - `fetch_cnt`=5 before the reset.
  - At the reset edge all counters and flags are 0, and the pending store is not written.
- Preload `wr_cnt` near wrap via 2^32−1 forced stores (or force internally), then one more store: `wr_cnt`=0.
